// File: rtl/frame_out_stream_packer.sv
// Packs 96-bit signed pixel writes from the effects core into a 24-bit RGB valid/ready stream.
// Optional FRAME_OUT_GRAY_EN adds a registered luma stage and emits {Y,Y,Y}.
module frame_out_stream_packer #(
    parameter int WIDTH      = 64,
    parameter int HEIGHT     = 64,
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [ADDR_W-1:0] frame_out_pixel_address0,
    input  logic              frame_out_pixel_ce0,
    input  logic              frame_out_pixel_we0,
    input  logic [95:0]       frame_out_pixel_d0,
    output logic [23:0]       m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              m_tuser,
    output logic              frame_done,
    output logic              overflow,
    output logic              addr_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]    CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]    CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    function automatic logic [7:0] clamp8(input logic [31:0] v);
        if (v[31])          return 8'd0;
        else if (|v[30:8])  return 8'hFF;
        else                return v[7:0];
    endfunction

    logic              in_vld_q, in_vld_d;
    logic [95:0]       in_data_q, in_data_d;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic              addr_err_q, addr_err_d;
    logic              cl_vld_q, cl_vld_d;
    logic [23:0]       cl_data_q, cl_data_d;
    logic [23:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    cnt_q, cnt_d;
    logic [23:0]       last_q, last_d;
    logic [ADDR_W-1:0] col_q, col_d, row_q, row_d;
    logic [1:0]        state_q, state_d;
    logic              overflow_q, overflow_d;

    logic              wr_fire, pop, push_ok, last_xfer;
    logic              push_vld;
    logic [23:0]       push_data;

`ifdef FRAME_OUT_GRAY_EN
    logic              gy_vld_q, gy_vld_d;
    logic [23:0]       gy_data_q, gy_data_d;
    logic [15:0]       gy_sum;
`endif

    always_comb begin
        wr_fire    = frame_out_pixel_ce0 && frame_out_pixel_we0;
        in_vld_d   = wr_fire;
        in_data_d  = wr_fire ? frame_out_pixel_d0 : in_data_q;
        wr_cnt_d   = wr_cnt_q;
        addr_err_d = addr_err_q;
        if (wr_fire) begin
            if (frame_out_pixel_address0 != wr_cnt_q) addr_err_d = 1'b1;
            wr_cnt_d = (wr_cnt_q == LAST_ADDR) ? '0 : wr_cnt_q + ADDR_ONE;
        end

        cl_vld_d  = in_vld_q;
        cl_data_d = {clamp8(in_data_q[95:64]), clamp8(in_data_q[63:32]), clamp8(in_data_q[31:0])};

`ifdef FRAME_OUT_GRAY_EN
        // Luma weights sum to 256, so the 16-bit sum cannot overflow for 8-bit inputs.
        gy_sum    = 16'd77 * {8'd0, cl_data_q[23:16]} + 16'd150 * {8'd0, cl_data_q[15:8]}
                  + 16'd29 * {8'd0, cl_data_q[7:0]};
        gy_vld_d  = cl_vld_q;
        gy_data_d = {3{gy_sum[15:8]}};
        push_vld  = gy_vld_q;
        push_data = gy_data_q;
`else
        push_vld  = cl_vld_q;
        push_data = cl_data_q;
`endif

        pop        = (cnt_q != '0) && m_tready;
        // A full FIFO still accepts a push when a pop frees a slot on the same edge.
        push_ok    = push_vld && ((cnt_q != CNT_FULL) || pop);
        overflow_d = overflow_q || (push_vld && !push_ok);
        wr_ptr_d   = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        last_d     = pop ? mem_q[rd_ptr_q] : last_q;
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase

        col_d = col_q;
        row_d = row_q;
        if (pop) begin
            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = (row_q == LAST_ROW) ? '0 : row_q + ADDR_ONE;
            end else begin
                col_d = col_q + ADDR_ONE;
            end
        end
        last_xfer = pop && (col_q == LAST_COL) && (row_q == LAST_ROW);

        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (wr_fire) state_d = ST_ACTIVE;
            ST_ACTIVE: if (last_xfer) state_d = ST_DONE;
            ST_DONE:   state_d = wr_fire ? ST_ACTIVE : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            in_vld_q   <= 1'b0;
            in_data_q  <= '0;
            wr_cnt_q   <= '0;
            addr_err_q <= 1'b0;
            cl_vld_q   <= 1'b0;
            cl_data_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            last_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            state_q    <= ST_IDLE;
            overflow_q <= 1'b0;
`ifdef FRAME_OUT_GRAY_EN
            gy_vld_q   <= 1'b0;
            gy_data_q  <= '0;
`endif
        end else begin
            in_vld_q   <= in_vld_d;
            in_data_q  <= in_data_d;
            wr_cnt_q   <= wr_cnt_d;
            addr_err_q <= addr_err_d;
            cl_vld_q   <= cl_vld_d;
            cl_data_q  <= cl_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            col_q      <= col_d;
            row_q      <= row_d;
            state_q    <= state_d;
            overflow_q <= overflow_d;
`ifdef FRAME_OUT_GRAY_EN
            gy_vld_q   <= gy_vld_d;
            gy_data_q  <= gy_data_d;
`endif
        end
    end

    always_ff @(posedge ap_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    // Markers derive from output-side counters; gated so an empty FIFO drives them low.
    assign m_tvalid   = (cnt_q != '0);
    assign m_tdata    = m_tvalid ? mem_q[rd_ptr_q] : last_q;
    assign m_tuser    = m_tvalid && (col_q == '0) && (row_q == '0);
    assign m_tlast    = m_tvalid && (col_q == LAST_COL);
    assign frame_done = (state_q == ST_DONE);
    assign overflow   = overflow_q;
    assign addr_err   = addr_err_q;

endmodule

// File: doc/frame_out_stream_packer.md
Name: frame_out_stream_packer

Overview:
- Downstream stage of the HLS effects core.
- Captures pixel writes from the core's BRAM-style frame_out write port: a 96-bit pixel made of three signed 32-bit channels.
- Clamps each channel to 8 bits, buffers the result in a FIFO, and emits a 24-bit RGB valid/ready stream with start-of-frame (tuser) and end-of-line (tlast) markers.
- Sits between the effects core and the video output / DMA path; also flags overflow and out-of-order writes.

Parameters:
WIDTH, 64, frame width in pixels (>=2)
HEIGHT, 64, frame height in lines (>=1)
ADDR_W, 12, pixel address width; 2^ADDR_W >= WIDTH*HEIGHT
FIFO_DEPTH, 16, output FIFO entries (power of 2, >=4)

Ports:
ap_clk  in  1  clock
ap_rst  in  1  synchronous active-high reset
frame_out_pixel_address0  in  ADDR_W  write address from core
frame_out_pixel_ce0  in  1  port enable
frame_out_pixel_we0  in  1  write enable; a write occurs only when ce0 and we0 are both 1
frame_out_pixel_d0  in  96  [95:64]=R, [63:32]=G, [31:0]=B, signed 32-bit each
m_tdata  out  24  [23:16]=R, [15:8]=G, [7:0]=B
m_tvalid  out  1  output data valid
m_tready  in  1  downstream ready
m_tlast  out  1  last pixel of a line
m_tuser  out  1  first pixel of a frame
frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted downstream
overflow  out  1  sticky: a pixel was dropped because the FIFO was full
addr_err  out  1  sticky: a write address did not match the expected sequential address

Behaviour:
- Reset (synchronous, ap_rst=1 at a rising edge):
  - All outputs go to 0.
  - FIFO is flushed; write count, output column and output row go to 0; FSM goes to IDLE.
  - Reset mid-frame discards all buffered pixels. No partial-frame completion: frame_done is not pulsed.
- Channel clamp: value <0 -> 0; value >255 -> 255; otherwise the low 8 bits.
- Capture pipeline:
  - A write at edge N is clamped into a register at N+1 and pushed into the FIFO at N+2.
  - m_tvalid rises no earlier than edge N+2 when the FIFO was empty.
- FIFO:
  - m_tdata, m_tlast and m_tuser come from the FIFO head.
  - A transfer occurs when m_tvalid and m_tready are both 1.
  - m_tdata, m_tlast and m_tuser hold stable while m_tvalid=1 and m_tready=0.
- Full FIFO:
  - A push with no pop in the same cycle drops the pixel and sets overflow.
  - Push and pop in the same cycle when full: the push is accepted.
- Empty FIFO: m_tvalid=0; m_tdata holds its last value.
- Address check:
  - Expected address = write count, which counts 0..WIDTH*HEIGHT-1 and wraps to 0.
  - A mismatch sets addr_err; the pixel is still pushed and the count still advances.
  - ce0=1 with we0=0 is ignored and does not advance the count.
- Markers come from output-side counters, advanced only on transfer:
  - m_tuser=1 when column=0 and row=0.
  - m_tlast=1 when column=WIDTH-1.
  - Column wraps to 0 at WIDTH-1, then row increments; row wraps to 0 at HEIGHT-1.
- FSM:
  - IDLE -> ACTIVE on the first write.
  - ACTIVE -> DONE on transfer of pixel (WIDTH-1, HEIGHT-1).
  - DONE: assert frame_done for one cycle, then -> IDLE. If another write arrives in the DONE cycle, go directly to ACTIVE.
  - The capture side never stalls, regardless of FSM state.
- Stickies (overflow, addr_err) clear only on ap_rst.

Optional Feature:
- Macro: FRAME_OUT_GRAY_EN.
- When defined:
  - One extra registered stage after the clamp computes Y = (77*R + 150*G + 29*B) >> 8 on the clamped 8-bit values, using a 16-bit intermediate.
  - m_tdata = {Y,Y,Y}.
  - Capture latency becomes N+3.
- When undefined: the stage is absent and latency is as above.

Test Plan:
- WIDTH=4, HEIGHT=2, m_tready=1; core writes addresses 0..7 with R=i, G=2i, B=3i:
  - 8 transfers in order.
  - m_tuser only on pixel 0; m_tlast on pixels 3 and 7.
  - frame_done pulses once, one cycle after the transfer of pixel 7.
  - overflow=0, addr_err=0.
- Clamp check: d0 channels R=-5, G=300, B=128 -> m_tdata=0x00FF80.
- Backpressure: m_tready=0, write 20 pixels into FIFO_DEPTH=16:
  - overflow=1.
  - Release ready: exactly 16 transfers, first-in order, data unchanged while stalled.
- Address sequence 0,1,3 -> addr_err=1 on the third write; 3 pixels still output.
- Reset mid-frame: ap_rst=1 for 1 cycle after 5 of 8 writes:
  - m_tvalid=0 and stickies=0 the next cycle; no frame_done.
  - A fresh 8-pixel frame then completes normally with m_tuser on its first pixel.
- FRAME_OUT_GRAY_EN defined, R=G=B=200 -> m_tdata=0xC8C8C8; first m_tvalid at N+3.
